seq_scan_ctrl: RTL
==================

// Module: seq_scan_ctrl
// PURPOSE
//  Controller that feeds a parallel word, MSB first, one bit per clock into an external
//  single-bit sequence-detector FSM and collects the detector's hit flag.
//  Sits between the mini-computer datapath (parallel words) and the serial detector.
//  Reports a hit count and the first hit position per word.
//  Can clear the detector between words or keep its state across words.
// PARAMETERS
//  WIDTH  8  bits per scanned word
//  CNT_W  4  hit_count width; must satisfy 2**CNT_W > WIDTH
//  POS_W  3  first_pos width; must satisfy 2**POS_W >= WIDTH
// PORTS
//  clk        in   1      single clock; all logic on posedge
//  reset      in   1      synchronous, active-high
//  start      in   1      request scan of data_in; accepted only when ready=1
//  data_in    in   WIDTH  word to scan; latched on accept
//  keep       in   1      latched on accept; 1 = keep detector state, 0 = clear first
//  ready      out  1      1 only in IDLE
//  det_w      out  1      serial bit to detector
//  det_rst_n  out  1      active-low reset to detector (registered)
//  det_z      in   1      detector hit flag (Mealy, combinational in det_w)
//  done       out  1      one-cycle pulse when scan completes
//  hit_count  out  CNT_W  hits in last word, saturating
//  hit_any    out  1      1 if at least one hit in last word
//  first_pos  out  POS_W  bit index (0 = MSB) of first hit; 0 if hit_any=0
// BEHAVIOUR
//  Reset (reset=1 at posedge), any state, including mid-scan:
//   - state=IDLE, ready=1, done=0, det_w=0, det_rst_n=0.
//   - hit_count=0, hit_any=0, first_pos=0; shift register and index cleared.
//  States: IDLE, CLR, SHIFT, DONE.
//  IDLE: ready=1, det_w=0, det_rst_n=1.
//   - On start=1: latch data_in/keep and zero hit_count/hit_any/first_pos/idx.
//   - Next state is CLR if keep=0, else SHIFT.
//   - start while not IDLE is ignored; it is not queued.
//  CLR: det_rst_n=0 for exactly this one cycle, det_w=0 -> SHIFT.
//  SHIFT: det_w = sreg[WIDTH-1], det_rst_n=1.
//   - det_z is sampled at the same posedge at which the detector consumes det_w.
//   - On det_z=1: hit_count++, saturating at 2**CNT_W-1.
//   - On det_z=1 with hit_any=0: first_pos<=idx, hit_any<=1.
//   - Every cycle: sreg<<=1, idx++. After bit idx=WIDTH-1 -> DONE.
//  DONE: done=1 for one cycle, det_w=0 -> IDLE.
//   - Result outputs hold until the next accepted start.
//  det_z is ignored outside SHIFT.
//  Latency, start accepted at edge k:
//   - keep=0: bits at cycles k+2..k+WIDTH+1, done at cycle k+WIDTH+2.
//   - keep=1: bits at cycles k+1..k+WIDTH, done at cycle k+WIDTH+1.
//  keep=1 leaves det_rst_n high, so the detector carries state across word boundaries.
//   - Overlapping patterns spanning two words are therefore detected.
//  start held high through DONE is accepted again at the first IDLE cycle (back-to-back).
//   - IDLE lasts exactly one cycle in that case.
// TESTING
//  (Detector replaced by bench stub unless noted.)
//  1. Reset mid-SHIFT (bit 3): next cycle ready=1, det_rst_n=0, outputs 0.
//     No done pulse is produced.
//  2. data_in=8'hB5, keep=0, stub det_z=1 at idx 2 and 5:
//     - CLR pulse seen; det_w sequence 1,0,1,1,0,1,0,1.
//     - done at k+10; hit_count=2, hit_any=1, first_pos=2.
//  3. keep=1, stub det_z=0 throughout:
//     - No CLR cycle; done at k+9; hit_count=0, hit_any=0, first_pos=0.
//  4. Stub det_z=1 on all bits, CNT_W=3:
//     - hit_count saturates at 7; first_pos=0.
//  5. start pulsed during SHIFT: ignored; exactly one done pulse.
//     start held high: second scan accepted the cycle after done.
//  6. With the real 110/101 overlap detector:
//     - Word1 8'h03 with keep=0, then word2 8'h40 with keep=1.
//     - Hits spanning the boundary are counted in word2; check against the golden model.

Source files
------------

// File: rtl/seq_scan_ctrl_if.sv
// rtl/seq_scan_ctrl_if.sv - host and detector signal bundle for the serial scan controller
interface seq_scan_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int POS_W = 3
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             keep;
  logic             ready;
  logic             det_w;
  logic             det_rst_n;
  logic             det_z;
  logic             done;
  logic [CNT_W-1:0] hit_count;
  logic             hit_any;
  logic [POS_W-1:0] first_pos;

  // Side that requests scans and plays the detector's hit flag.
  modport master (
    output start, data_in, keep, det_z,
    input  ready, det_w, det_rst_n, done, hit_count, hit_any, first_pos
  );

  // Side implemented by the scan controller.
  modport slave (
    input  start, data_in, keep, det_z,
    output ready, det_w, det_rst_n, done, hit_count, hit_any, first_pos
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - serialises a word MSB first into a bit-serial detector and tallies hits
module seq_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int POS_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  seq_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state;
  // sreg holds the bits not yet presented; det_w already carries the current one.
  logic [WIDTH-1:0] sreg;
  logic [POS_W-1:0] idx;

  // Controller FSM; every output is registered and set for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      sreg          <= '0;
      idx           <= '0;
      bus.ready     <= 1'b1;
      bus.done      <= 1'b0;
      bus.det_w     <= 1'b0;
      bus.det_rst_n <= 1'b0;
      bus.hit_count <= '0;
      bus.hit_any   <= 1'b0;
      bus.first_pos <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          bus.det_rst_n <= 1'b1;
          bus.det_w     <= 1'b0;
          if (bus.start) begin
            bus.ready     <= 1'b0;
            bus.hit_count <= '0;
            bus.hit_any   <= 1'b0;
            bus.first_pos <= '0;
            idx           <= '0;
            if (bus.keep) begin
              // Detector state is kept, so the first bit goes out immediately.
              state     <= SHIFT;
              bus.det_w <= bus.data_in[WIDTH-1];
              sreg      <= {bus.data_in[WIDTH-2:0], 1'b0};
            end else begin
              state         <= CLR;
              bus.det_rst_n <= 1'b0;
              sreg          <= bus.data_in;
            end
          end
        end

        CLR: begin
          state         <= SHIFT;
          bus.det_rst_n <= 1'b1;
          bus.det_w     <= sreg[WIDTH-1];
          sreg          <= {sreg[WIDTH-2:0], 1'b0};
        end

        SHIFT: begin
          // The detector consumes det_w at this same edge, so det_z belongs to bit idx.
          if (bus.det_z) begin
            if (bus.hit_count != CNT_MAX) bus.hit_count <= bus.hit_count + 1'b1;
            if (!bus.hit_any) begin
              bus.hit_any   <= 1'b1;
              bus.first_pos <= idx;
            end
          end
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state     <= DONE;
            bus.det_w <= 1'b0;
            bus.done  <= 1'b1;
          end else begin
            bus.det_w <= sreg[WIDTH-1];
            sreg      <= {sreg[WIDTH-2:0], 1'b0};
          end
        end

        DONE: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
          bus.det_w <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
